// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int PC_WIDTH = 32;
  localparam int INSTR_W  = 32;

  // All-zero word doubles as the MIPS NOP (sll $0,$0,0).
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                valid;
    logic [INSTR_W-1:0]  instr;
    logic [PC_WIDTH-1:0] pc4;
  } ifid_t;

  // Contents of IF/ID when it holds no real instruction.
  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: INSTR_NOP, pc4: '0};

  // A byte target that is not on a word boundary.
  function automatic logic is_misaligned(input logic [PC_WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, memory and IF/ID signals.
interface if_stage_if;
  import mips_pkg::*;

  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                halt;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [INSTR_W-1:0]  imem_data;
  logic                ifid_valid;
  logic [INSTR_W-1:0]  ifid_instr;
  logic [PC_WIDTH-1:0] ifid_pc4;
  logic [31:0]         fetch_count;
  logic                err_misaligned;

  // The fetch stage drives the memory address and the IF/ID view.
  modport master (
    input  stall, redirect_valid, redirect_pc, halt, imem_data,
    output imem_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count, err_misaligned
  );

  // Hazard unit, EX, instruction memory and decode sit on this side.
  modport slave (
    output stall, redirect_valid, redirect_pc, halt, imem_data,
    input  imem_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count, err_misaligned
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise the contents are held.
module if_id_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_load,
  input  logic  i_flush,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  // Capture a fetched word, insert a bubble, or hold for decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= IFID_BUBBLE;
    end else if (i_flush) begin
      r_q <= IFID_BUBBLE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC selection, boot/run/halt FSM and
// delivered-instruction counter, feeding the IF/ID register.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = 32'd4
)(
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  bus
);

  fetch_state_t        r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_fetch_count;
  logic                r_err_misaligned;

  logic [PC_WIDTH-1:0] w_pc_next_seq;
  logic [PC_WIDTH-1:0] w_redirect_target;
  logic                w_capture;
  logic                w_flush;
  ifid_t               w_ifid_d;
  ifid_t               w_ifid_q;

  assign w_pc_next_seq     = r_pc + PC_STEP;
  assign w_redirect_target = bus.redirect_pc & ~32'h3;

  // A capture happens only on a plain running edge; redirect, stall and halt all win over it.
  assign w_capture = !bus.redirect_valid && !bus.stall && (r_state == S_RUN) && !bus.halt;

  // Wrong-path flush on redirect; bubble on entering or sitting in halt unless decode stalls.
  assign w_flush = bus.redirect_valid ||
                   (!bus.stall && (((r_state == S_RUN) && bus.halt) || (r_state == S_HALT)));

  assign w_ifid_d = '{valid: 1'b1, instr: bus.imem_data, pc4: w_pc_next_seq};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_capture),
    .i_flush (w_flush),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  // Fetch FSM with PC, counter and sticky error, resolved in redirect > stall > halt > advance order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_BOOT;
      r_pc             <= RESET_PC;
      r_fetch_count    <= 32'd0;
      r_err_misaligned <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc <= w_redirect_target;
      if (is_misaligned(bus.redirect_pc)) begin
        r_err_misaligned <= 1'b1;
      end
      r_state <= (r_state == S_HALT) ? S_HALT : S_RUN;
    end else if (!bus.stall) begin
      case (r_state)
        S_BOOT: begin
          r_state <= bus.halt ? S_HALT : S_RUN;
        end
        S_RUN: begin
          if (bus.halt) begin
            r_state <= S_HALT;
          end else begin
            r_pc          <= w_pc_next_seq;
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        S_HALT: begin
          if (!bus.halt) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign bus.imem_addr      = r_pc;
  assign bus.ifid_valid     = w_ifid_q.valid;
  assign bus.ifid_instr     = w_ifid_q.instr;
  assign bus.ifid_pc4       = w_ifid_q.pc4;
  assign bus.fetch_count    = r_fetch_count;
  assign bus.err_misaligned = r_err_misaligned;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for the instruction-fetch stage.
module tb_if_stage;

  logic clk;
  logic rst_n;

  logic [31:0] mem [128];

  int nCompared;
  int nMismatched;

  typedef struct {
    logic        st;
    logic        rv;
    logic        h;
    logic [31:0] rpc;
    logic [31:0] expPc;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc4;
    logic [31:0] expCount;
    logic        expErr;
  } vec_t;

  vec_t vecs [26];

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational instruction memory, word-indexed by address bits 8:2.
  assign bus.imem_data = mem[bus.imem_addr[8:2]];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [31:0] pc, input logic valid,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic [31:0] count, input logic err);
    checkOutput({tag, " imem_addr"},      bus.imem_addr,              pc);
    checkOutput({tag, " ifid_valid"},     {31'b0, bus.ifid_valid},     {31'b0, valid});
    checkOutput({tag, " ifid_instr"},     bus.ifid_instr,             instr);
    checkOutput({tag, " ifid_pc4"},       bus.ifid_pc4,               pc4);
    checkOutput({tag, " fetch_count"},    bus.fetch_count,            count);
    checkOutput({tag, " err_misaligned"}, {31'b0, bus.err_misaligned}, {31'b0, err});
  endtask

  // Drive one cycle's inputs, take the edge, then sample 1 time unit later.
  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc, input logic h);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.halt           = h;
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input int i);
    applyStimulus(vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].h);
    checkState($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expValid, vecs[i].expInstr,
               vecs[i].expPc4, vecs[i].expCount, vecs[i].expErr);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;

    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0007;

    //           st rv h  rpc            pc             v  instr          pc4            count  err
    vecs[0]  = '{0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0,         32'd0, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,         32'h4,         1, 32'h2008_0005, 32'h4,         32'd1, 0};
    vecs[2]  = '{0, 0, 0, 32'h0,         32'h8,         1, 32'h2009_0007, 32'h8,         32'd2, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,         32'h8,         1, 32'h2009_0007, 32'h8,         32'd2, 0};
    vecs[4]  = '{1, 0, 0, 32'h0,         32'h8,         1, 32'h2009_0007, 32'h8,         32'd2, 0};
    vecs[5]  = '{1, 0, 0, 32'h0,         32'h8,         1, 32'h2009_0007, 32'h8,         32'd2, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,         32'hC,         1, 32'hA000_0002, 32'hC,         32'd3, 0};
    vecs[7]  = '{1, 1, 0, 32'h40,        32'h40,        0, 32'h0,         32'h0,         32'd3, 0};
    vecs[8]  = '{0, 0, 0, 32'h0,         32'h44,        1, 32'hA000_0010, 32'h44,        32'd4, 0};
    vecs[9]  = '{0, 1, 0, 32'h42,        32'h40,        0, 32'h0,         32'h0,         32'd4, 1};
    vecs[10] = '{0, 0, 0, 32'h0,         32'h44,        1, 32'hA000_0010, 32'h44,        32'd5, 1};
    vecs[11] = '{0, 0, 1, 32'h0,         32'h44,        0, 32'h0,         32'h0,         32'd5, 1};
    vecs[12] = '{0, 0, 1, 32'h0,         32'h44,        0, 32'h0,         32'h0,         32'd5, 1};
    vecs[13] = '{0, 0, 1, 32'h0,         32'h44,        0, 32'h0,         32'h0,         32'd5, 1};
    vecs[14] = '{0, 0, 1, 32'h0,         32'h44,        0, 32'h0,         32'h0,         32'd5, 1};
    vecs[15] = '{0, 0, 0, 32'h0,         32'h44,        0, 32'h0,         32'h0,         32'd5, 1};
    vecs[16] = '{0, 0, 0, 32'h0,         32'h48,        1, 32'hA000_0011, 32'h48,        32'd6, 1};
    vecs[17] = '{0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         32'd6, 1};
    vecs[18] = '{0, 0, 0, 32'h0,         32'h0,         1, 32'hA000_007F, 32'h0,         32'd7, 1};
    vecs[19] = '{0, 1, 0, 32'h200,       32'h200,       0, 32'h0,         32'h0,         32'd7, 1};
    vecs[20] = '{0, 0, 0, 32'h0,         32'h204,       1, 32'h2008_0005, 32'h204,       32'd8, 1};
    vecs[21] = '{0, 0, 1, 32'h0,         32'h204,       0, 32'h0,         32'h0,         32'd8, 1};
    vecs[22] = '{0, 1, 1, 32'h10,        32'h10,        0, 32'h0,         32'h0,         32'd8, 1};
    vecs[23] = '{0, 0, 1, 32'h0,         32'h10,        0, 32'h0,         32'h0,         32'd8, 1};
    vecs[24] = '{0, 0, 0, 32'h0,         32'h10,        0, 32'h0,         32'h0,         32'd8, 1};
    vecs[25] = '{0, 0, 0, 32'h0,         32'h14,        1, 32'hA000_0004, 32'h14,        32'd9, 1};

    // Power-on reset values, before release.
    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt           = 1'b0;
    #3;
    checkState("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) runVec(i);

    // Reach PC=0x1C with a valid instruction, then pulse reset mid-cycle.
    applyStimulus(1'b0, 1'b1, 32'h18, 1'b0);
    checkState("pre-reset redirect", 32'h18, 1'b0, 32'h0, 32'h0, 32'd9, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkState("pre-reset fetch", 32'h1C, 1'b1, 32'hA000_0006, 32'h1C, 32'd10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) runVec(i);

    // Halt raised straight out of boot: nothing is fetched until it drops.
    resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("boot halt", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkState("boot halt hold", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkState("boot halt release", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkState("boot halt fetch", 32'h4, 1'b1, 32'h2008_0005, 32'h4, 32'd1, 1'b0);

    // Redirect on the boot cycle moves straight into running.
    resetDut();
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0);
    checkState("boot redirect", 32'h8, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkState("boot redirect fetch", 32'hC, 1'b1, 32'hA000_0002, 32'hC, 32'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
